// File: rtl/adc_if_pkg.sv
// Shared definitions for the serial ADC link: frame geometry defaults,
// master state encoding and a small counter-window helper.
package adc_if_pkg;

    // Default frame geometry, also used by the ADC-side simulation model
    localparam int CMD_WIDTH      = 16;
    localparam int SAMPLE_WIDTH   = 14;
    localparam int FRAME_CYCLES   = 36;
    localparam int TX_START       = 1;
    localparam int RX_START       = 22;
    localparam int CS_HIGH_CYCLES = 4;

    // Width of the frame/gap cycle counter
    localparam int CNT_W = 6;

    // Master state encoding
    localparam logic [1:0] ADC_M_IDLE  = 2'd0;
    localparam logic [1:0] ADC_M_FRAME = 2'd1;
    localparam logic [1:0] ADC_M_GAP   = 2'd2;

    // True when cnt lies in the inclusive range [first, last]
    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] first,
                                       input logic [CNT_W-1:0] last);
        return (cnt >= first) && (cnt <= last);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs, one chain per bit.
module sync_2ff
    import adc_if_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] sync_1_q;
    logic [WIDTH-1:0] sync_2_q;

    // Two register stages; the second stage is the first one safe to use
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_1_q <= '0;
            sync_2_q <= '0;
        end else begin
            sync_1_q <= i_d;
            sync_2_q <= sync_1_q;
        end
    end

    assign o_q = sync_2_q;

endmodule

// File: rtl/adc_master.sv
// FPGA-side initiator for the serial ADC link. Each accepted request runs one
// chip-select-low frame that shifts a command out and captures two sample
// lanes, followed by a chip-select-high guard gap. All outputs are registered.
module adc_master
    import adc_if_pkg::*;
#(
    parameter int CMD_WIDTH      = adc_if_pkg::CMD_WIDTH,
    parameter int SAMPLE_WIDTH   = adc_if_pkg::SAMPLE_WIDTH,
    parameter int FRAME_CYCLES   = adc_if_pkg::FRAME_CYCLES,
    parameter int TX_START       = adc_if_pkg::TX_START,
    parameter int RX_START       = adc_if_pkg::RX_START,
    parameter int CS_HIGH_CYCLES = adc_if_pkg::CS_HIGH_CYCLES
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [CMD_WIDTH-1:0]    i_cmd,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [SAMPLE_WIDTH-1:0] o_sample_0,
    output logic [SAMPLE_WIDTH-1:0] o_sample_1,
    output logic                    o_fpga_chip_select_n,
    output logic                    o_fpga_data,
    input  logic [1:0]              i_fpga_data
);

    // Geometry must fit inside the frame and the 6-bit counter
    if (TX_START + CMD_WIDTH > FRAME_CYCLES) begin : g_chk_tx
        $fatal(1, "adc_master: command window exceeds frame");
    end
    if (RX_START + SAMPLE_WIDTH > FRAME_CYCLES) begin : g_chk_rx
        $fatal(1, "adc_master: sample window exceeds frame");
    end
    if (FRAME_CYCLES >= 64) begin : g_chk_frame
        $fatal(1, "adc_master: FRAME_CYCLES must be below 64");
    end
    if (CS_HIGH_CYCLES < 1 || CS_HIGH_CYCLES > 64) begin : g_chk_gap
        $fatal(1, "adc_master: CS_HIGH_CYCLES must be 1..64");
    end

    localparam logic [CNT_W-1:0] TX_FIRST   = CNT_W'(TX_START);
    localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(TX_START + CMD_WIDTH - 1);
    localparam logic [CNT_W-1:0] RX_FIRST   = CNT_W'(RX_START);
    localparam logic [CNT_W-1:0] RX_LAST    = CNT_W'(RX_START + SAMPLE_WIDTH - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_HIGH_CYCLES - 1);

    logic [1:0]              sync_q;

    logic [1:0]              state_q,   state_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [CMD_WIDTH-1:0]    shreg_q,   shreg_d;
    logic [SAMPLE_WIDTH-1:0] cap0_q,    cap0_d;
    logic [SAMPLE_WIDTH-1:0] cap1_q,    cap1_d;
    logic [SAMPLE_WIDTH-1:0] sample0_q, sample0_d;
    logic [SAMPLE_WIDTH-1:0] sample1_q, sample1_d;
    logic                    done_q,    done_d;
    logic                    busy_q,    busy_d;
    logic                    cs_n_q,    cs_n_d;
    logic                    data_q,    data_d;

    // Resynchronise the two sample lanes coming from the ADC pins
    sync_2ff #(
        .WIDTH (2)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_fpga_data),
        .o_q     (sync_q)
    );

    // Next-state, counter, shift/capture and registered-output logic.
    // Pin outputs are derived from the next state/count so that the flopped
    // value lines up with the frame cycle it belongs to.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        cap0_d    = cap0_q;
        cap1_d    = cap1_q;
        sample0_d = sample0_q;
        sample1_d = sample1_q;
        done_d    = 1'b0;
        data_d    = 1'b0;

        case (state_q)
            ADC_M_IDLE: begin
                if (i_start) begin
                    state_d = ADC_M_FRAME;
                    cnt_d   = '0;
                    shreg_d = i_cmd;
                end
            end
            ADC_M_FRAME: begin
                if (in_window(cnt_q, RX_FIRST, RX_LAST)) begin
                    cap0_d = {cap0_q[SAMPLE_WIDTH-2:0], sync_q[0]};
                    cap1_d = {cap1_q[SAMPLE_WIDTH-2:0], sync_q[1]};
                end
                if (cnt_q == FRAME_LAST) begin
                    // Last capture may land in this very cycle, so publish cap*_d
                    state_d   = ADC_M_GAP;
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    sample0_d = cap0_d;
                    sample1_d = cap1_d;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ADC_M_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ADC_M_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ADC_M_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Command bits leave MSB first during the transmit window
        if (state_d == ADC_M_FRAME && in_window(cnt_d, TX_FIRST, TX_LAST)) begin
            data_d  = shreg_d[CMD_WIDTH-1];
            shreg_d = {shreg_d[CMD_WIDTH-2:0], 1'b0};
        end

        cs_n_d = (state_d != ADC_M_FRAME);
        busy_d = (state_d != ADC_M_IDLE);
    end

    // State and output registers; reset aborts any frame in progress
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ADC_M_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            cap0_q    <= '0;
            cap1_q    <= '0;
            sample0_q <= '0;
            sample1_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            data_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            cap0_q    <= cap0_d;
            cap1_q    <= cap1_d;
            sample0_q <= sample0_d;
            sample1_q <= sample1_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            cs_n_q    <= cs_n_d;
            data_q    <= data_d;
        end
    end

    assign o_busy               = busy_q;
    assign o_done               = done_q;
    assign o_sample_0           = sample0_q;
    assign o_sample_1           = sample1_q;
    assign o_fpga_chip_select_n = cs_n_q;
    assign o_fpga_data          = data_q;

endmodule

// File: tb/tb_adc_master.sv
// Directed bench for adc_master with a cycle-accurate ADC-side model that
// records the command and drives two sample lanes.
module tb_adc_master;
    import adc_if_pkg::*;

    logic        clk;
    logic        i_rst_n;
    logic        i_start;
    logic [15:0] i_cmd;
    logic        o_busy;
    logic        o_done;
    logic [13:0] o_sample_0;
    logic [13:0] o_sample_1;
    logic        o_fpga_chip_select_n;
    logic        o_fpga_data;
    logic [1:0]  i_fpga_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // ADC-side model state
    logic        m_rst;
    int          m_cnt;
    logic [15:0] m_wr;
    logic [13:0] m_s0;
    logic [13:0] m_s1;

    localparam int PIN_FIRST = RX_START - 2;

    adc_master dut (
        .i_clk                (clk),
        .i_rst_n              (i_rst_n),
        .i_start              (i_start),
        .i_cmd                (i_cmd),
        .o_busy               (o_busy),
        .o_done               (o_done),
        .o_sample_0           (o_sample_0),
        .o_sample_1           (o_sample_1),
        .o_fpga_chip_select_n (o_fpga_chip_select_n),
        .o_fpga_data          (o_fpga_data),
        .i_fpga_data          (i_fpga_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign m_rst = ~i_rst_n;

    // ADC model: m_cnt is the frame cycle that ends at this edge
    always @(posedge clk or posedge m_rst) begin
        if (m_rst) begin
            m_cnt       <= 0;
            m_wr        <= '0;
            i_fpga_data <= 2'b00;
        end else if (!o_fpga_chip_select_n) begin
            if (m_cnt == 0)
                m_wr <= '0;
            else if (m_cnt >= TX_START && m_cnt < TX_START + CMD_WIDTH)
                m_wr <= {m_wr[14:0], o_fpga_data};
            if (m_cnt + 1 >= PIN_FIRST && m_cnt + 1 < PIN_FIRST + SAMPLE_WIDTH)
                i_fpga_data <= {m_s1[SAMPLE_WIDTH - 1 - (m_cnt + 1 - PIN_FIRST)],
                                m_s0[SAMPLE_WIDTH - 1 - (m_cnt + 1 - PIN_FIRST)]};
            else
                i_fpga_data <= 2'b00;
            m_cnt <= m_cnt + 1;
        end else begin
            m_cnt       <= 0;
            i_fpga_data <= 2'b00;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Start a frame in the current (idle) cycle and check every pin cycle.
    // Returns at the negedge of the first idle cycle after the gap.
    task automatic run_frame(input logic [15:0] cmd, input logic [13:0] s0,
                             input logic [13:0] s1, input bit hold, input int inj_f);
        m_s0    = s0;
        m_s1    = s1;
        i_cmd   = cmd;
        i_start = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 40; f++) begin
            if (f == inj_f) begin
                i_start = 1'b1;
                i_cmd   = 16'h1234;
            end else if (!hold) begin
                i_start = 1'b0;
            end
            check($sformatf("cs f%0d", f), o_fpga_chip_select_n, (f < 36) ? 1'b0 : 1'b1);
            check($sformatf("data f%0d", f), o_fpga_data,
                  (f >= 1 && f <= 16) ? cmd[16 - f] : 1'b0);
            check($sformatf("busy f%0d", f), o_busy, 1'b1);
            check($sformatf("done f%0d", f), o_done, (f == 36) ? 1'b1 : 1'b0);
            if (f == 36) begin
                check("sample0", o_sample_0, s0);
                check("sample1", o_sample_1, s1);
            end
            @(negedge clk);
        end
        if (!hold) i_start = 1'b0;
        check("idle busy", o_busy, 1'b0);
        check("idle cs", o_fpga_chip_select_n, 1'b1);
        check("idle done", o_done, 1'b0);
        check("held sample0", o_sample_0, s0);
        check("held sample1", o_sample_1, s1);
        check("adc cmd", m_wr, cmd);
    endtask

    initial begin
        int dones;
        int cs_lows;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_cmd   = '0;
        m_s0    = '0;
        m_s1    = '0;
        repeat (3) @(negedge clk);
        check("rst cs", o_fpga_chip_select_n, 1'b1);
        check("rst data", o_fpga_data, 1'b0);
        check("rst busy", o_busy, 1'b0);
        check("rst done", o_done, 1'b0);
        check("rst s0", o_sample_0, 14'h0);
        check("rst s1", o_sample_1, 14'h0);
        i_rst_n = 1'b1;
        while (cyc < 10) @(negedge clk);

        // Loopback and pin timing: start in cycle 10
        run_frame(16'hBEEF, 14'h2A5C, 14'h1337, 1'b0, -1);

        // Start pulse during frame cycle 10 is ignored
        run_frame(16'hC3A5, 14'h0F0F, 14'h30C3, 1'b0, 10);
        @(negedge clk);
        check("no extra frame cs", o_fpga_chip_select_n, 1'b1);
        check("no extra frame busy", o_busy, 1'b0);

        // Back-to-back with start held high
        run_frame(16'h0001, 14'h0155, 14'h2AAA, 1'b1, -1);
        run_frame(16'hFFFF, 14'h1FFF, 14'h2001, 1'b0, -1);

        // Reset in frame cycle 20
        m_s0    = 14'h1111;
        m_s1    = 14'h2222;
        i_cmd   = 16'h5555;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (20) @(negedge clk);
        i_rst_n = 1'b0;
        #1;
        check("abort cs", o_fpga_chip_select_n, 1'b1);
        check("abort busy", o_busy, 1'b0);
        check("abort data", o_fpga_data, 1'b0);
        check("abort s0", o_sample_0, 14'h0);
        check("abort s1", o_sample_1, 14'h0);
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        dones   = 0;
        cs_lows = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (o_done) dones++;
            if (!o_fpga_chip_select_n) cs_lows++;
        end
        check("abort no done", dones, 0);
        check("abort no frame", cs_lows, 0);
        run_frame(16'hA55A, 14'h2468, 14'h1357, 1'b0, -1);

        // Edge values
        run_frame(16'h8001, 14'h3FFF, 14'h0000, 1'b0, -1);
        run_frame(16'h8001, 14'h0000, 14'h3FFF, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
